// File: rtl/nnrv_pkg.sv
// rtl/nnrv_pkg.sv - shared widths and parameter defaults for the writeback stage
// Holds the data width, register count, register-index width and the default
// starvation limit used by nnrv_wb and nnrv_wb_arb.
package nnrv_pkg;

   localparam int unsigned XLEN_DEF       = 32;
   localparam int unsigned REG_NUM_DEF    = 32;
   localparam int unsigned REG_IDX_W      = 5;
   localparam int unsigned STARVE_MAX_DEF = 2;

endpackage

// File: rtl/nnrv_wb_arb.sv
// rtl/nnrv_wb_arb.sv - two-requester writeback arbiter with ALU starvation guard
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_alu_valid/i_lsu_valid writeback requests
//   o_alu_gnt/o_lsu_gnt     one-hot (or zero) grants, combinational
module nnrv_wb_arb
   import nnrv_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_alu_valid,
   input  logic i_lsu_valid,
   output logic o_alu_gnt,
   output logic o_lsu_gnt
);

   localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

   logic [1:0] starve_q, starve_d;

   // LSU wins by default; the ALU takes over once it has watched STARVE_LIM
   // consecutive LSU grants. Both grants are forced low during reset.
   always_comb begin
      o_alu_gnt = 1'b0;
      o_lsu_gnt = 1'b0;
      if (!i_rst) begin
         o_alu_gnt = i_alu_valid && (!i_lsu_valid || (starve_q == STARVE_LIM));
         o_lsu_gnt = i_lsu_valid && !o_alu_gnt;
      end
   end

   // Count LSU grants only while the ALU is waiting; saturate at 3.
   always_comb begin
      starve_d = starve_q;
      if (!i_alu_valid || o_alu_gnt) begin
         starve_d = 2'd0;
      end else if (o_lsu_gnt && (starve_q != 2'd3)) begin
         starve_d = starve_q + 2'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_q <= 2'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/nnrv_wb.sv
// rtl/nnrv_wb.sv - writeback stage: arbitration, pending-write scoreboard, register-file write port
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_alu_valid/rd/data, o_alu_ready   ALU writeback request
//   i_lsu_valid/rd/data, o_lsu_ready   load-unit writeback request
//   i_issue_en, i_issue_rd             decode marks a destination as pending
//   i_q1/i_q2, o_q1_busy/o_q2_busy     source hazard queries
//   o_w_en, o_w, o_w_reg               registered register-file write port
module nnrv_wb
   import nnrv_pkg::*;
#(
   parameter int unsigned XLEN       = XLEN_DEF,
   parameter int unsigned REG_NUM    = REG_NUM_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_alu_valid,
   input  logic [REG_IDX_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]      i_alu_data,
   output logic                 o_alu_ready,
   input  logic                 i_lsu_valid,
   input  logic [REG_IDX_W-1:0] i_lsu_rd,
   input  logic [XLEN-1:0]      i_lsu_data,
   output logic                 o_lsu_ready,
   input  logic                 i_issue_en,
   input  logic [REG_IDX_W-1:0] i_issue_rd,
   input  logic [REG_IDX_W-1:0] i_q1,
   input  logic [REG_IDX_W-1:0] i_q2,
   output logic                 o_q1_busy,
   output logic                 o_q2_busy,
   output logic                 o_w_en,
   output logic [REG_IDX_W-1:0] o_w,
   output logic [XLEN-1:0]      o_w_reg
);

   logic                 alu_gnt, lsu_gnt, gnt;
   logic [REG_IDX_W-1:0] gnt_rd;
   logic [XLEN-1:0]      gnt_data;

   logic                 w_en_q, w_en_d;
   logic [REG_IDX_W-1:0] w_q, w_d;
   logic [XLEN-1:0]      w_reg_q, w_reg_d;
   logic [REG_NUM-1:0]   pending_q, pending_d;

   nnrv_wb_arb #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_alu_valid (i_alu_valid),
      .i_lsu_valid (i_lsu_valid),
      .o_alu_gnt   (alu_gnt),
      .o_lsu_gnt   (lsu_gnt)
   );

   assign o_alu_ready = alu_gnt;
   assign o_lsu_ready = lsu_gnt;

   always_comb begin
      gnt      = alu_gnt || lsu_gnt;
      gnt_rd   = alu_gnt ? i_alu_rd   : i_lsu_rd;
      gnt_data = alu_gnt ? i_alu_data : i_lsu_data;
   end

   // Writes to x0 are accepted but never reach the register file.
   always_comb begin
      w_en_d  = gnt && (gnt_rd != '0);
      w_d     = gnt ? gnt_rd   : w_q;
      w_reg_d = gnt ? gnt_data : w_reg_q;
   end

   // Clear before set so a same-cycle issue to the retiring rd keeps it pending.
   always_comb begin
      pending_d = pending_q;
      for (int i = 1; i < int'(REG_NUM); i++) begin
         if (gnt && (gnt_rd == i[REG_IDX_W-1:0])) begin
            pending_d[i] = 1'b0;
         end
         if (i_issue_en && (i_issue_rd == i[REG_IDX_W-1:0])) begin
            pending_d[i] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   // Hazard queries see registered state only; x0 is never busy.
   always_comb begin
      o_q1_busy = 1'b0;
      o_q2_busy = 1'b0;
      for (int i = 1; i < int'(REG_NUM); i++) begin
         if (i_q1 == i[REG_IDX_W-1:0]) begin
            o_q1_busy = pending_q[i];
         end
         if (i_q2 == i[REG_IDX_W-1:0]) begin
            o_q2_busy = pending_q[i];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         w_en_q    <= 1'b0;
         w_q       <= '0;
         w_reg_q   <= '0;
         pending_q <= '0;
      end else begin
         w_en_q    <= w_en_d;
         w_q       <= w_d;
         w_reg_q   <= w_reg_d;
         pending_q <= pending_d;
      end
   end

   assign o_w_en  = w_en_q;
   assign o_w     = w_q;
   assign o_w_reg = w_reg_q;

endmodule

// File: tb/tb_nnrv_wb.sv
// tb/tb_nnrv_wb.sv - self-checking bench for nnrv_wb
module tb_nnrv_wb;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_alu_valid, i_lsu_valid, i_issue_en;
   logic [4:0]  i_alu_rd, i_lsu_rd, i_issue_rd, i_q1, i_q2;
   logic [31:0] i_alu_data, i_lsu_data;
   logic        o_alu_ready, o_lsu_ready, o_q1_busy, o_q2_busy, o_w_en;
   logic [4:0]  o_w;
   logic [31:0] o_w_reg;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   nnrv_wb dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_alu_valid (i_alu_valid),
      .i_alu_rd    (i_alu_rd),
      .i_alu_data  (i_alu_data),
      .o_alu_ready (o_alu_ready),
      .i_lsu_valid (i_lsu_valid),
      .i_lsu_rd    (i_lsu_rd),
      .i_lsu_data  (i_lsu_data),
      .o_lsu_ready (o_lsu_ready),
      .i_issue_en  (i_issue_en),
      .i_issue_rd  (i_issue_rd),
      .i_q1        (i_q1),
      .i_q2        (i_q2),
      .o_q1_busy   (o_q1_busy),
      .o_q2_busy   (o_q2_busy),
      .o_w_en      (o_w_en),
      .o_w         (o_w),
      .o_w_reg     (o_w_reg)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        ea;
      logic        el;
   } vec_t;

   typedef struct {
      logic        en;
      logic [4:0]  w;
      logic [31:0] data;
      logic        chk_wd;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[14];
   logic [4:0]  m_w;
   logic [31:0] m_d;
   logic        m_nz;
   logic        q1_at_drive;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         chk({name, ":sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({name, ":w_en"}, 32'(o_w_en), 32'(e.en));
         if (e.chk_wd) begin
            chk({name, ":w"},     32'(o_w), 32'(e.w));
            chk({name, ":w_reg"}, o_w_reg,  e.data);
         end
      end
   endtask

   // One clock of writeback traffic: drive at negedge, check readies,
   // predict the registered write, then check it just after the posedge.
   task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic ea, input logic el, input string name);
      exp_t        e;
      logic [4:0]  rd;
      logic [31:0] d;
      @(negedge clk);
      i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
      i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ld;
      #1;
      q1_at_drive = o_q1_busy;
      chk({name, ":alu_ready"}, 32'(o_alu_ready), 32'(ea));
      chk({name, ":lsu_ready"}, 32'(o_lsu_ready), 32'(el));
      e.en = 1'b0; e.w = m_w; e.data = m_d; e.chk_wd = m_nz;
      if (ea || el) begin
         rd = ea ? ard : lrd;
         d  = ea ? ad  : ld;
         m_w = rd; m_d = d; m_nz = (rd != 5'd0);
         e.en = (rd != 5'd0); e.w = rd; e.data = d; e.chk_wd = (rd != 5'd0);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      i_alu_valid = 1'b0;
      i_lsu_valid = 1'b0;
      pop_check(name);
   endtask

   task automatic idle(input string name);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, name);
   endtask

   initial begin
      i_rst = 1'b1;
      i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'd0;
      i_lsu_valid = 1'b0; i_lsu_rd = 5'd0; i_lsu_data = 32'd0;
      i_issue_en = 1'b0; i_issue_rd = 5'd0; i_q1 = 5'd0; i_q2 = 5'd0;
      q1_at_drive = 1'b0;

      //         av    ard    ad             lv    lrd    ld             ea    el
      vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'd0,         1'b1, 1'b0};
      vecs[1]  = '{1'b1, 5'd1,  32'h0000_00A1, 1'b1, 5'd2,  32'h0000_00B1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 5'd1,  32'h0000_00A2, 1'b1, 5'd2,  32'h0000_00B2, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 5'd1,  32'h0000_00A3, 1'b1, 5'd2,  32'h0000_00B3, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd1,  32'h0000_00A4, 1'b1, 5'd2,  32'h0000_00B4, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 5'd1,  32'h0000_00A5, 1'b1, 5'd6,  32'h0000_00B5, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 5'd1,  32'h0000_00A6, 1'b1, 5'd2,  32'h0000_00B6, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 5'd1,  32'h0000_00A7, 1'b1, 5'd2,  32'h0000_00B7, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 5'd8,  32'h0000_00A8, 1'b1, 5'd2,  32'h0000_00B8, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'd0,         1'b1, 1'b0};
      vecs[10] = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd31, 32'hCAFE_0031, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 5'd31, 32'h1357_9BDF, 1'b0, 5'd0,  32'd0,         1'b1, 1'b0};
      vecs[12] = '{1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b0, 1'b0};
      vecs[13] = '{1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 1'b1};

      // Reset: requests and an issue presented during reset are ignored.
      @(negedge clk);
      i_alu_valid = 1'b1; i_lsu_valid = 1'b1; i_issue_en = 1'b1; i_issue_rd = 5'd3;
      #1;
      chk("rst:alu_ready", 32'(o_alu_ready), 32'd0);
      chk("rst:lsu_ready", 32'(o_lsu_ready), 32'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0; i_alu_valid = 1'b0; i_lsu_valid = 1'b0; i_issue_en = 1'b0;
      i_q1 = 5'd3;
      #1;
      chk("rst:w_en",  32'(o_w_en), 32'd0);
      chk("rst:w",     32'(o_w), 32'd0);
      chk("rst:w_reg", o_w_reg, 32'd0);
      chk("rst:busy3", 32'(o_q1_busy), 32'd0);
      m_w = 5'd0; m_d = 32'd0; m_nz = 1'b1;

      for (int k = 0; k < 14; k++) begin
         cycle(vecs[k].av, vecs[k].ard, vecs[k].ad, vecs[k].lv, vecs[k].lrd, vecs[k].ld,
               vecs[k].ea, vecs[k].el, $sformatf("vec%0d", k));
      end

      // Issue rd7, see it busy, retire it through the LSU.
      i_issue_en = 1'b1; i_issue_rd = 5'd7;
      idle("c3_issue");
      i_issue_en = 1'b0; i_q1 = 5'd7;
      #1;
      chk("c3:busy_after_issue", 32'(o_q1_busy), 32'd1);
      idle("c3_idle1");
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777, 1'b0, 1'b1, "c3_wb");
      chk("c3:busy_no_bypass", 32'(q1_at_drive), 32'd1);
      chk("c3:busy_after_wb", 32'(o_q1_busy), 32'd0);

      // Issue and writeback to the same rd in one cycle: set wins.
      i_issue_en = 1'b1; i_issue_rd = 5'd9; i_q1 = 5'd9;
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_9999, 1'b0, 1'b1, "c4_wb");
      i_issue_en = 1'b0;
      #1;
      chk("c4:busy9", 32'(o_q1_busy), 32'd1);
      idle("c4_idle");
      chk("c4:busy9_held", 32'(o_q1_busy), 32'd1);

      // Issue to x0 is ignored.
      i_issue_en = 1'b1; i_issue_rd = 5'd0;
      idle("c5_issue0");
      i_issue_en = 1'b0; i_q1 = 5'd0; i_q2 = 5'd0;
      #1;
      chk("c5:q1_busy0", 32'(o_q1_busy), 32'd0);
      chk("c5:q2_busy0", 32'(o_q2_busy), 32'd0);

      // Pending 3 and 4, build up starvation, then reset mid-traffic.
      i_issue_en = 1'b1; i_issue_rd = 5'd3;
      idle("c6_issue3");
      i_issue_rd = 5'd4;
      idle("c6_issue4");
      i_issue_en = 1'b0; i_q1 = 5'd3; i_q2 = 5'd4;
      #1;
      chk("c6:busy3", 32'(o_q1_busy), 32'd1);
      chk("c6:busy4", 32'(o_q2_busy), 32'd1);
      cycle(1'b1, 5'd20, 32'h0000_2020, 1'b1, 5'd21, 32'h0000_2121, 1'b0, 1'b1, "c6_pre1");
      cycle(1'b1, 5'd20, 32'h0000_2020, 1'b1, 5'd12, 32'h0000_1212, 1'b0, 1'b1, "c6_pre2");
      @(negedge clk);
      i_rst = 1'b1;
      i_alu_valid = 1'b1; i_alu_rd = 5'd13; i_alu_data = 32'h0000_1313;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd14; i_lsu_data = 32'h0000_1414;
      i_issue_en = 1'b1; i_issue_rd = 5'd5;
      #1;
      chk("c6:rst_alu_ready", 32'(o_alu_ready), 32'd0);
      chk("c6:rst_lsu_ready", 32'(o_lsu_ready), 32'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0; i_alu_valid = 1'b0; i_lsu_valid = 1'b0; i_issue_en = 1'b0;
      #1;
      chk("c6:w_en",  32'(o_w_en), 32'd0);
      chk("c6:w",     32'(o_w), 32'd0);
      chk("c6:w_reg", o_w_reg, 32'd0);
      chk("c6:busy3_cleared", 32'(o_q1_busy), 32'd0);
      chk("c6:busy4_cleared", 32'(o_q2_busy), 32'd0);
      i_q1 = 5'd5; i_q2 = 5'd9;
      #1;
      chk("c6:busy5_discarded", 32'(o_q1_busy), 32'd0);
      chk("c6:busy9_cleared", 32'(o_q2_busy), 32'd0);
      m_w = 5'd0; m_d = 32'd0; m_nz = 1'b1;
      // Starvation counter was at its limit before reset; LSU must win again.
      cycle(1'b1, 5'd22, 32'h0000_2222, 1'b1, 5'd23, 32'h0000_2323, 1'b0, 1'b1, "c6_post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
